axi_slv_rd_mem: RTL

- Memory-side read backend for the AXI slave read controller.
- Consumes its per-beat read requests (rd_req_en / rd_base_addr) and drives a synchronous single-port SRAM read port.
- Returns rd_result_en / rd_result_data in request order with fixed latency.
- Has no backpressure toward the controller, so it accepts one request per cycle, unconditionally.

---
 rtl/axi_slv_rd_mem.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi_slv_rd_mem.sv
// Memory-side read backend: decodes per-beat read requests onto a synchronous SRAM port
// and returns in-order results with fixed latency MEM_LAT (+1 when OUT_REG).
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module axi_slv_rd_mem #(
    parameter int unsigned                MEM_DEPTH = 1024,
    parameter int unsigned                MEM_LAT   = 1,
    parameter int unsigned                OUT_REG   = 1,
    parameter logic [`AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      rd_req_en,
    input  logic [`AXI_ADDR_WIDTH-1:0]                rd_base_addr,
    output logic                                      rd_result_en,
    output logic [`AXI_DATA_WIDTH-1:0]                rd_result_data,
    output logic                                      rd_result_err,
    output logic                                      mem_cs,
    output logic [$clog2(MEM_DEPTH)-1:0]              mem_addr,
    input  logic [`AXI_DATA_WIDTH-1:0]                mem_rdata,
    output logic [$clog2(MEM_LAT+OUT_REG+1)+1-1:0]    ost_cnt
);

    localparam int unsigned DW  = `AXI_DATA_WIDTH;
    localparam int unsigned AW  = `AXI_ADDR_WIDTH;
    localparam int unsigned IW  = $clog2(MEM_DEPTH);
    localparam int unsigned BSH = $clog2(DW / 8);
    localparam int unsigned LT  = MEM_LAT + OUT_REG;
    localparam int unsigned CW  = $clog2(LT + 1) + 1;

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("axi_slv_rd_mem: MEM_LAT must be in 1..4");
    end

    // Address decode: word index relative to BASE_ADDR, sub-word bits dropped.
    logic [AW-1:0] off_c;
    logic [AW-1:0] idx_c;
    logic          in_range_c;

    always_comb begin
        off_c      = rd_base_addr - BASE_ADDR;
        idx_c      = off_c >> BSH;
        in_range_c = (rd_base_addr >= BASE_ADDR) && (idx_c < AW'(MEM_DEPTH));
    end

    assign mem_cs   = rd_req_en & in_range_c;
    assign mem_addr = idx_c[IW-1:0];

    // Tracking pipeline aligned with the SRAM read latency.
    logic [MEM_LAT-1:0] pv_q, pv_d;
    logic [MEM_LAT-1:0] pe_q, pe_d;
    logic               last_v;
    logic               last_e;

    always_comb begin
        pv_d = MEM_LAT'({pv_q, rd_req_en});
        pe_d = MEM_LAT'({pe_q, rd_req_en & ~in_range_c});
    end

    assign last_v = pv_q[MEM_LAT-1];
    assign last_e = pe_q[MEM_LAT-1];

    logic [CW-1:0] ost_q, ost_d;

    always_comb begin
        ost_d = ost_q;
        if (rd_req_en && !rd_result_en) begin
            ost_d = ost_q + CW'(1);
        end else if (!rd_req_en && rd_result_en) begin
            ost_d = ost_q - CW'(1);
        end
    end

    assign ost_cnt = ost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q  <= '0;
            pe_q  <= '0;
            ost_q <= '0;
        end else begin
            pv_q  <= pv_d;
            pe_q  <= pe_d;
            ost_q <= ost_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic          res_en_q, res_en_d;
        logic          res_err_q, res_err_d;
        logic [DW-1:0] res_data_q, res_data_d;

        // Data only updates on a valid beat so it holds between results.
        always_comb begin
            res_en_d   = last_v;
            res_err_d  = last_v & last_e;
            res_data_d = res_data_q;
            if (last_v) begin
                res_data_d = last_e ? '0 : mem_rdata;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_en_q   <= 1'b0;
                res_err_q  <= 1'b0;
                res_data_q <= '0;
            end else begin
                res_en_q   <= res_en_d;
                res_err_q  <= res_err_d;
                res_data_q <= res_data_d;
            end
        end

        assign rd_result_en   = res_en_q;
        assign rd_result_err  = res_err_q;
        assign rd_result_data = res_data_q;
    end else begin : g_comb
        assign rd_result_en   = last_v;
        assign rd_result_err  = last_v & last_e;
        assign rd_result_data = (last_v & ~last_e) ? mem_rdata : '0;
    end

endmodule
